// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: framer state encoding,
// clock/baud constants and the default start-of-frame marker.
package uart_pkg;

    localparam int unsigned CLK_HZ      = 12000000;
    localparam int unsigned BAUD        = 115200;
    localparam logic [7:0]  DEFAULT_SOF = 8'hA5;

    // Framer FSM states; the framer advances at most one state per received byte.
    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    // Running checksum step: 8-bit wraparound add, carry discarded.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/framer_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM with a synchronous write
// port and a registered read port (one cycle read latency). Only the read
// register is reset so the array can map onto block RAM.
module framer_buf #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Write port: one byte per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: registered output, cleared by reset, read-before-write on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 8'd0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_framer.sv
// Packet framer behind the UART receiver. Assembles SOF, LEN, payload, CSUM
// frames from byte strobes, keeps a validated payload in framer_buf until the
// consumer acknowledges it, and pulses one error strobe per dropped frame or
// byte. Optional inter-byte timeout: define UART_FRAMER_TIMEOUT_EN.
//
// Handshakes: byte_available is a one-cycle strobe qualifying rx_byte with no
// back-pressure (a byte that cannot be taken is dropped and reported via
// overrun); pkt_valid acts as "valid" and pkt_ack as "ready" - a packet is
// consumed on the first cycle where both are high, and pkt_ack is ignored
// whenever pkt_valid is low. The FSM state is visible as state_q.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SOF_BYTE     = DEFAULT_SOF,
    parameter int unsigned TIMEOUT_CLKS = 12000,
    localparam int unsigned AW          = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_byte,
    input  logic          byte_available,
    output logic          pkt_valid,
    output logic [AW:0]   pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          pkt_ack,
    output logic          csum_err,
    output logic          len_err,
    output logic          overrun,
    output logic          timeout_err
);

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          csum_err_q, csum_err_d;
    logic          len_err_q, len_err_d;
    logic          overrun_q, overrun_d;
    logic          wr_en;
    logic          len_ok;
    logic          last_byte;
    logic          to_fire;

    // LEN is legal when 1..MAX_LEN; widened so MAX_LEN=256 compares correctly.
    assign len_ok    = (rx_byte != 8'd0) && (9'(rx_byte) <= 9'(MAX_LEN));
    // Current payload byte is the final one of the frame.
    assign last_byte = (({1'b0, idx_q} + (AW+1)'(1)) == len_q);

`ifdef UART_FRAMER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);

    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          to_active;
    logic          to_err_q;

    assign to_active = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    // Fires on the idle cycle that would bring the count to TIMEOUT_CLKS.
    assign to_fire   = to_active && !byte_available && (to_cnt_q == CW'(TIMEOUT_CLKS - 1));

    // Idle counter: cleared by any byte, by firing, and outside the mid-frame states.
    always_comb begin
        to_cnt_d = '0;
        if (to_active && !byte_available && !to_fire) begin
            to_cnt_d = to_cnt_q + CW'(1);
        end
    end

    // Timeout counter and its error pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_fire;
        end
    end

    assign timeout_err = to_err_q;
`else
    // Without the timeout a truncated frame waits indefinitely for more bytes.
    assign to_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state and datapath control; one step per received byte.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        csum_err_d = 1'b0;
        len_err_d  = 1'b0;
        overrun_d  = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (byte_available && (rx_byte == SOF_BYTE)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_available) begin
                    if (len_ok) begin
                        len_d   = (AW+1)'(rx_byte);
                        sum_d   = rx_byte;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_PAYLOAD: begin
                if (byte_available) begin
                    wr_en = 1'b1;
                    sum_d = csum_add(sum_q, rx_byte);
                    idx_d = idx_q + AW'(1);
                    if (last_byte) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (byte_available) begin
                    if (rx_byte == sum_q) begin
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        csum_err_d = 1'b1;
                        state_d    = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                // Buffer is owned by the consumer: every arriving byte is lost,
                // including one that lands in the same cycle as the ack.
                if (byte_available) begin
                    overrun_d = 1'b1;
                end
                if (pkt_ack) begin
                    valid_d = 1'b0;
                    state_d = S_HUNT;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // Timeout only fires on byte-free cycles, so it never races the case above.
        if (to_fire) begin
            state_d = S_HUNT;
        end
    end

    // State, frame bookkeeping and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HUNT;
            len_q      <= '0;
            sum_q      <= 8'd0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            csum_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            csum_err_q <= csum_err_d;
            len_err_q  <= len_err_d;
            overrun_q  <= overrun_d;
        end
    end

    framer_buf #(
        .DEPTH(MAX_LEN)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (wr_en),
        .wr_addr_i(idx_q),
        .wr_data_i(rx_byte),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data)
    );

    assign pkt_valid = valid_q;
    assign pkt_len   = len_q;
    assign csum_err  = csum_err_q;
    assign len_err   = len_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: directed vector table, hand-written
// corner sequences (overrun on ack, reset mid-frame, timeout) and randomized
// frames checked against a frame-level reference model.
module tb_uart_rx_framer;
    import uart_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int AW      = 4;
    localparam int TO_CLKS = 200;
    localparam int GAP     = 104;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_byte;
    logic          byte_available;
    logic          pkt_valid;
    logic [AW:0]   pkt_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_ack;
    logic          csum_err;
    logic          len_err;
    logic          overrun;
    logic          timeout_err;

    always #5 clk = ~clk;

    uart_rx_framer #(
        .MAX_LEN(MAX_LEN),
        .SOF_BYTE(8'hA5),
        .TIMEOUT_CLKS(TO_CLKS)
    ) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .byte_available(byte_available),
        .pkt_valid(pkt_valid), .pkt_len(pkt_len), .rd_addr(rd_addr), .rd_data(rd_data),
        .pkt_ack(pkt_ack), .csum_err(csum_err), .len_err(len_err), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int n_csum = 0, n_len = 0, n_ovr = 0, n_to = 0;
    int s_csum, s_len, s_ovr, s_to;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse counter plus per-cycle exclusivity of the error strobes.
    always @(negedge clk) begin
        int hot;
        hot = 0;
        if (!rst) begin
            if (csum_err === 1'b1)    begin n_csum++; hot++; end
            if (len_err === 1'b1)     begin n_len++;  hot++; end
            if (overrun === 1'b1)     begin n_ovr++;  hot++; end
            if (timeout_err === 1'b1) begin n_to++;   hot++; end
            if (hot > 0) check("err_exclusive", 32'(hot > 1), 32'd0);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte = b;
        byte_available = 1'b1;
        @(negedge clk);
        byte_available = 1'b0;
        rx_byte = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int gmin, input int gmax);
        foreach (q[i]) send_byte(q[i], $urandom_range(gmin, gmax));
    endtask

    task automatic snap();
        s_csum = n_csum; s_len = n_len; s_ovr = n_ovr; s_to = n_to;
    endtask

    task automatic check_errs(input string tag, input int ec, input int el, input int eo, input int et);
        repeat (2) @(negedge clk);
        check({tag, "_csum_err"}, 32'(n_csum - s_csum), 32'(ec));
        check({tag, "_len_err"},  32'(n_len - s_len),   32'(el));
        check({tag, "_overrun"},  32'(n_ovr - s_ovr),   32'(eo));
        check({tag, "_timeout"},  32'(n_to - s_to),     32'(et));
    endtask

    task automatic read_check(input string name, input int addr);
        rd_addr = AW'(addr);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check(name, 32'(rd_data), 32'(exp_q.pop_front()));
        end
    endtask

    // Checks a held packet: valid, length, payload in the given address order.
    task automatic check_packet(input string tag, input logic [7:0] pay[$], input int order[$]);
        check({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd1);
        check({tag, "_pkt_len"}, 32'(pkt_len), 32'(pay.size()));
        foreach (order[i]) begin
            exp_q.push_back(pay[order[i]]);
            read_check({tag, "_rd_data"}, order[i]);
        end
    endtask

    task automatic do_ack(input string tag);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(pkt_valid), 32'd0);
    endtask

    function automatic logic [7:0] model_csum(input logic [7:0] len, input logic [7:0] pay[$]);
        int s;
        s = int'(len);
        foreach (pay[i]) s = s + int'(pay[i]);
        return 8'(s % 256);
    endfunction

    function automatic void seq_order(input int n, output int order[$]);
        order = {};
        for (int i = 0; i < n; i++) order.push_back(i);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          n;
        logic [47:0] bytes;     // first byte in the top occupied octet
        logic        exp_valid;
        int          exp_csum;
        int          exp_len;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] pay[$];
    logic [7:0] frm[$];
    int         order[$];
    logic [7:0] b;
    logic [7:0] len_b;
    logic [7:0] cs;
    int         kind, njunk, nlen, novr, tmp, j;

    initial begin
        vecs[0] = '{"v_basic",    6, 48'hA5_03_11_22_33_69, 1'b1, 0, 0};
        vecs[1] = '{"v_badcsum",  5, 48'h00_A5_02_10_20_00, 1'b0, 1, 0};
        vecs[2] = '{"v_len1",     4, 48'h00_00_A5_01_7F_80, 1'b1, 0, 0};
        vecs[3] = '{"v_len0",     4, 48'h00_00_00_FF_A5_00, 1'b0, 0, 1};
        vecs[4] = '{"v_len17",    2, 48'h00_00_00_00_A5_11, 1'b0, 0, 1};
        vecs[5] = '{"v_sof_data", 5, 48'h00_A5_02_A5_A5_4C, 1'b1, 0, 0};
        vecs[6] = '{"v_csum_wrap",5, 48'h00_A5_02_FF_FF_00, 1'b1, 0, 0};

        rst = 1'b1; rx_byte = 8'd0; byte_available = 1'b0; rd_addr = '0; pkt_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pkt_valid", 32'(pkt_valid), 32'd0);
        check("reset_pkt_len", 32'(pkt_len), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_errs", 32'({csum_err, len_err, overrun, timeout_err}), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(S_HUNT));
        rst = 1'b0;
        @(negedge clk);

        // ack with no packet held is ignored
        do_ack("idle_ack");
        check("idle_ack_state", 32'(dut.state_q), 32'(S_HUNT));

        // ---- table-driven directed frames ----
        foreach (vecs[v]) begin
            snap();
            for (int i = 0; i < vecs[v].n; i++) begin
                b = vecs[v].bytes[8*(vecs[v].n-1-i) +: 8];
                send_byte(b, GAP);
            end
            check_errs(vecs[v].name, vecs[v].exp_csum, vecs[v].exp_len, 0, 0);
            check({vecs[v].name, "_valid"}, 32'(pkt_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                pay = {};
                for (int i = 2; i < vecs[v].n - 1; i++) pay.push_back(vecs[v].bytes[8*(vecs[v].n-1-i) +: 8]);
                seq_order(pay.size(), order);
                check_packet(vecs[v].name, pay, order);
                do_ack(vecs[v].name);
            end else begin
                check({vecs[v].name, "_state"}, 32'(dut.state_q), 32'(S_HUNT));
            end
        end

        // ---- maximum-length frame ----
        snap();
        pay = {};
        for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'($urandom));
        frm = {8'hA5, 8'(MAX_LEN)};
        foreach (pay[i]) frm.push_back(pay[i]);
        frm.push_back(model_csum(8'(MAX_LEN), pay));
        send_seq(frm, GAP, GAP);
        check_errs("maxlen", 0, 0, 0, 0);
        seq_order(MAX_LEN, order);
        check_packet("maxlen", pay, order);
        do_ack("maxlen");

        // ---- held packet, three bytes dropped, last one on the ack cycle ----
        frm = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq(frm, GAP, GAP);
        snap();
        send_byte(8'h01, GAP);
        send_byte(8'hA5, GAP);
        pay = {8'h11, 8'h22, 8'h33};
        seq_order(3, order);
        check_packet("hold", pay, order);
        rx_byte = 8'hA5; byte_available = 1'b1; pkt_ack = 1'b1;
        @(negedge clk);
        byte_available = 1'b0; pkt_ack = 1'b0;
        check("hold_valid_after_ack", 32'(pkt_valid), 32'd0);
        check_errs("hold", 0, 0, 3, 0);
        snap();
        frm = {8'hA5, 8'h01, 8'h7F, 8'h80};
        send_seq(frm, GAP, GAP);
        check_errs("after_hold", 0, 0, 0, 0);
        pay = {8'h7F};
        seq_order(1, order);
        check_packet("after_hold", pay, order);
        do_ack("after_hold");

        // ---- reset mid-payload ----
        snap();
        frm = {8'hA5, 8'h04, 8'h01};
        send_seq(frm, GAP, GAP);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("midrst_pkt_len", 32'(pkt_len), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        check("midrst_errs", 32'({csum_err, len_err, overrun, timeout_err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        frm = {8'hA5, 8'h02, 8'h33, 8'h44, 8'h79};
        send_seq(frm, GAP, GAP);
        check_errs("midrst", 0, 0, 0, 0);
        pay = {8'h33, 8'h44};
        seq_order(2, order);
        check_packet("midrst", pay, order);
        do_ack("midrst");

        // ---- inter-byte timeout ----
        snap();
        send_byte(8'hA5, GAP);
        send_byte(8'h02, GAP);
        send_byte(8'h01, 1);
        repeat (TO_CLKS + 10) @(negedge clk);
`ifdef UART_FRAMER_TIMEOUT_EN
        check_errs("timeout", 0, 0, 0, 1);
        check("timeout_state", 32'(dut.state_q), 32'(S_HUNT));
        snap();
        frm = {8'hA5, 8'h01, 8'h42, 8'h43};
        send_seq(frm, GAP, GAP);
        check_errs("post_timeout", 0, 0, 0, 0);
        pay = {8'h42};
`else
        check_errs("no_timeout", 0, 0, 0, 0);
        check("no_timeout_valid", 32'(pkt_valid), 32'd0);
        snap();
        send_byte(8'h05, GAP);
        send_byte(8'h08, GAP);
        check_errs("resume", 0, 0, 0, 0);
        pay = {8'h01, 8'h05};
`endif
        seq_order(pay.size(), order);
        check_packet("after_idle", pay, order);
        do_ack("after_idle");

        // ---- randomized frames vs frame-level model ----
        for (int it = 0; it < 30; it++) begin
            kind  = $urandom_range(0, 5);  // 0-2 valid, 3 bad csum, 4 LEN=0, 5 LEN>MAX
            njunk = $urandom_range(0, 3);
            frm = {};
            for (int k = 0; k < njunk; k++) begin
                do b = 8'($urandom); while (b == 8'hA5);
                frm.push_back(b);
            end
            frm.push_back(8'hA5);
            pay = {};
            if (kind <= 3) begin
                nlen = $urandom_range(1, MAX_LEN);
                for (int k = 0; k < nlen; k++) pay.push_back(8'($urandom));
                len_b = 8'(nlen);
                cs = model_csum(len_b, pay);
                if (kind == 3) cs = cs ^ 8'($urandom_range(1, 255));
                frm.push_back(len_b);
                foreach (pay[k]) frm.push_back(pay[k]);
                frm.push_back(cs);
            end else if (kind == 4) begin
                frm.push_back(8'h00);
            end else begin
                frm.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            end
            snap();
            send_seq(frm, 1, 12);
            check_errs("rnd", (kind == 3) ? 1 : 0, (kind >= 4) ? 1 : 0, 0, 0);
            check("rnd_valid", 32'(pkt_valid), 32'(kind <= 2));
            if (kind <= 2) begin
                novr = $urandom_range(0, 2);
                snap();
                for (int k = 0; k < novr; k++) send_byte(8'($urandom), $urandom_range(1, 5));
                check_errs("rnd_hold", 0, 0, novr, 0);
                seq_order(pay.size(), order);
                for (int k = order.size() - 1; k > 0; k--) begin
                    j = $urandom_range(0, k);
                    tmp = order[k]; order[k] = order[j]; order[j] = tmp;
                end
                check_packet("rnd", pay, order);
                do_ack("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
